// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer.
package reaction_pkg;

    // Width of every millisecond count and result register.
    localparam int unsigned MS_W       = 14;
    // Default saturating limit and anticipation threshold, in ms.
    localparam int unsigned MAX_MS_DEF = 9999;
    localparam int unsigned MIN_MS_DEF = 100;

    // Measurement FSM states.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARMED       = 3'd1,
        ST_TIMING      = 3'd2,
        ST_DONE        = 3'd3,
        ST_FALSE_START = 3'd4,
        ST_TIMEOUT     = 3'd5
    } state_e;

    // Status flags shown to the outside world, one per result-holding state.
    typedef struct packed {
        logic valid;
        logic false_start;
        logic timeout;
        logic timing;
    } status_t;

    // One-hot status decode of a state.
    function automatic status_t decode_status(input state_e s);
        status_t st;
        st             = '0;
        st.valid       = (s == ST_DONE);
        st.false_start = (s == ST_FALSE_START);
        st.timeout     = (s == ST_TIMEOUT);
        st.timing      = (s == ST_TIMING);
        return st;
    endfunction

endpackage

// File: rtl/reaction_timer_keySync.sv
// Push-button synchronizer with a one-cycle rising-edge press pulse.
// After reset the edge detector stays blind until the synchronizer chain
// and the edge history hold real samples, so a button held through reset
// release never looks like a fresh press.
module keySync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_key,
    output logic o_press
);

    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [FILL_W-1:0]      fill_q;
    logic                   press_q;
    logic                   sync_key;
    logic                   ready;

    assign sync_key = sync_q[SYNC_STAGES-1];
    assign ready    = (fill_q == FILL_DONE);
    assign o_press  = press_q;

    // Shift the raw key through the synchronizer chain.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_key};
        end
    end

    // Count cycles since reset until the edge history is trustworthy.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            fill_q <= '0;
        end else if (!ready) begin
            fill_q <= fill_q + 1'b1;
        end
    end

    // Remember the last synchronized level and emit the rising-edge pulse.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= sync_key;
            press_q <= ready & sync_key & ~prev_q;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms on request, times from the start lights to the
// first key press in milliseconds, classifies the result as genuine,
// false start or timeout, and tracks the best genuine time since reset.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned MAX_MS      = MAX_MS_DEF,
    parameter int unsigned MIN_MS      = MIN_MS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_arst,
    input  logic            i_tickMs,
    input  logic            i_arm,
    input  logic            i_go,
    input  logic            i_key,
    input  logic            i_clear,
    output logic [MS_W-1:0] o_reactionMs,
    output logic [MS_W-1:0] o_bestMs,
    output logic            o_valid,
    output logic            o_falseStart,
    output logic            o_timeout,
    output logic            o_timing,
    output state_e          o_state
);

    // Parameter sanity, rejected at elaboration.
    if (MAX_MS >= (1 << MS_W)) begin : g_max_too_big
        $error("reaction_timer: MAX_MS must be below 2**MS_W");
    end
    if (MIN_MS > MAX_MS) begin : g_min_above_max
        $error("reaction_timer: MIN_MS must not exceed MAX_MS");
    end
    if (SYNC_STAGES < 2) begin : g_sync_too_short
        $error("reaction_timer: SYNC_STAGES must be at least 2");
    end

    localparam logic [MS_W-1:0] MAX_C = MS_W'(MAX_MS);
    localparam logic [MS_W-1:0] MIN_C = MS_W'(MIN_MS);

    logic            press;

    state_e          state_q,  state_d;
    logic [MS_W-1:0] count_q,  count_d;
    logic [MS_W-1:0] react_q,  react_d;
    logic [MS_W-1:0] best_q,   best_d;
    status_t         status_q;

    keySync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key_sync (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_key   (i_key),
        .o_press (press)
    );

    // Next-state and datapath decisions; clear outranks every other event.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        react_d = react_q;
        best_d  = best_q;
        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Presses are ignored until the race is armed.
                    if (i_arm) begin
                        state_d = ST_ARMED;
                        count_d = '0;
                    end
                end
                ST_ARMED: begin
                    // A press before or together with the lights is anticipation.
                    if (press) begin
                        state_d = ST_FALSE_START;
                        react_d = count_q;
                    end else if (i_go) begin
                        state_d = ST_TIMING;
                        count_d = '0;
                    end
                end
                ST_TIMING: begin
                    // The press wins over a tick in the same cycle, so that
                    // tick is not counted. i_go is not watched here at all.
                    if (press) begin
                        react_d = count_q;
                        if (count_q >= MIN_C) begin
                            state_d = ST_DONE;
                            if (count_q < best_q) begin
                                best_d = count_q;
                            end
                        end else begin
                            state_d = ST_FALSE_START;
                        end
                    end else if (i_tickMs) begin
                        if (count_q == MAX_C) begin
                            state_d = ST_TIMEOUT;
                            react_d = MAX_C;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_DONE, ST_FALSE_START, ST_TIMEOUT: begin
                    // Results are held until cleared; arming is ignored.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Register state, datapath and the one-hot status decode together.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            react_q  <= '0;
            best_q   <= MAX_C;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            react_q  <= react_d;
            best_q   <= best_d;
            status_q <= decode_status(state_d);
        end
    end

    assign o_reactionMs = react_q;
    assign o_bestMs     = best_q;
    assign o_valid      = status_q.valid;
    assign o_falseStart = status_q.false_start;
    assign o_timeout    = status_q.timeout;
    assign o_timing     = status_q.timing;
    assign o_state      = state_q;

endmodule
